// File: rtl/reed_solomon_decoder_wr_combiner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reed_solomon_decoder_wr_combiner_if                             |
// | Purpose  : Bundles the decoded-symbol stream and the CCI-P c1 write        |
// |            channel seen by the write combiner.                             |
// | Signals  : in_valid/in_data/in_ready  - symbol stream from the RS decoder  |
// |            c1_almfull                 - c1 TX almost-full                  |
// |            wr_rsp_valid               - one pulse per write response       |
// |            wr_valid/wr_addr/wr_data   - c1 write request                   |
// | Modports : master - the combiner (consumes symbols, issues writes)         |
// |            slave  - the environment (decoder + host channel)               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface reed_solomon_decoder_wr_combiner_if #(
  parameter int SYM_WIDTH  = 8,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 42
);
  localparam int C_LW = LINE_BYTES * 8;

  logic                  in_valid;
  logic [SYM_WIDTH-1:0]  in_data;
  logic                  in_ready;
  logic                  c1_almfull;
  logic                  wr_rsp_valid;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [C_LW-1:0]       wr_data;

  modport master (
    input  in_valid, in_data, c1_almfull, wr_rsp_valid,
    output in_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data, c1_almfull, wr_rsp_valid,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/reed_solomon_decoder_wr_combiner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reed_solomon_decoder_wr_combiner                                |
// | Purpose  : Packs decoded RS symbols (first symbol in the MSBs) into cache  |
// |            lines held in a pool of NUM_LINES buffers, issues them on the   |
// |            CCI-P c1 write channel, zero-pads a partial last line on flush, |
// |            counts write responses and finally writes a completion word     |
// |            (value 1) to the DSM address and raises done.                   |
// | Ports    : clk, reset_n (async, active-low)                                |
// |            start, base_addr, size_lines, dsm_addr - job setup, latched on  |
// |                                                     start                  |
// |            flush          - end-of-stream pulse (RUN only)                 |
// |            bus (master)   - symbol stream + c1 write channel               |
// |            done           - high from DSM issue until next start           |
// |            stat_bp_cycles - RUN cycles with in_valid && !in_ready          |
// |            stat_af_cycles - cycles where c1_almfull blocked an issue       |
// | Options  : RS_WR_COMBINER_STATS_EN - builds the two statistics counters;   |
// |            when undefined the stat ports are tied to zero.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reed_solomon_decoder_wr_combiner #(
  parameter int SYM_WIDTH  = 8,
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 4,
  parameter int ADDR_WIDTH = 42,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  size_lines,
  input  logic [ADDR_WIDTH-1:0] dsm_addr,
  input  logic                  flush,
  reed_solomon_decoder_wr_combiner_if.master bus,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  stat_bp_cycles,
  output logic [CNT_WIDTH-1:0]  stat_af_cycles
);

  localparam int C_LW    = LINE_BYTES * 8;
  localparam int C_SYMS  = C_LW / SYM_WIDTH;
  localparam int C_PTR_W = (C_SYMS > 1) ? $clog2(C_SYMS) : 1;
  localparam int C_BIT_W = $clog2(C_LW);
  localparam int C_IDX_W = $clog2(NUM_LINES);
  localparam int C_OCC_W = $clog2(NUM_LINES + 1);

  localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(C_SYMS - 1);
  localparam logic [C_OCC_W-1:0] C_OCC_FULL = C_OCC_W'(NUM_LINES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DSM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_dsm;
  logic [CNT_WIDTH-1:0]  r_size;
  logic [CNT_WIDTH-1:0]  r_committed;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_rsp_cnt;
  logic [C_PTR_W-1:0]    r_sym_ptr;
  logic [C_IDX_W-1:0]    r_fill_idx;
  logic [C_IDX_W-1:0]    r_drain_idx;
  logic [C_OCC_W-1:0]    r_occ;
  logic                  r_commit_d;
  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [C_LW-1:0]       r_wr_data;
  logic                  r_done;

  logic [C_LW-1:0]       r_line [NUM_LINES];

  logic                  w_start_ok;
  logic [C_OCC_W-1:0]    w_pool_used;
  logic                  w_pool_free;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_flush_commit;
  logic                  w_commit;
  logic                  w_issue_state;
  logic                  w_issue;
  logic                  w_dsm_issue;
  logic [C_BIT_W-1:0]    w_fill_bits;
  logic [C_BIT_W-1:0]    w_sym_hi;
  logic [C_LW-1:0]       w_pad_mask;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // occ only counts a committed line one edge after the commit (this gives
  // the two-edge commit-to-write latency). r_commit_d covers that gap so the
  // buffer just committed is never treated as free and overwritten.
  assign w_pool_used = r_occ + C_OCC_W'(r_commit_d);
  assign w_pool_free = (w_pool_used < C_OCC_FULL);

  assign w_in_ready = (r_state == S_RUN) && w_pool_free && (r_committed < r_size);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = w_accept && (r_sym_ptr == C_PTR_LAST);

  assign w_flush_commit = (r_state == S_FLUSH) && (r_sym_ptr != '0) && w_pool_free;
  assign w_commit       = w_last || w_flush_commit;

  assign w_issue_state = (r_state == S_RUN) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
  assign w_issue       = w_issue_state && (r_occ != '0) && !bus.c1_almfull;
  assign w_dsm_issue   = (r_state == S_DSM) && !bus.c1_almfull;

  // Bit position of the current symbol, and a mask keeping only the symbols
  // already written into the partial line (everything below them is zeroed).
  assign w_fill_bits = C_BIT_W'(r_sym_ptr) * C_BIT_W'(SYM_WIDTH);
  assign w_sym_hi    = C_BIT_W'(C_LW - 1) - w_fill_bits;
  assign w_pad_mask  = ~({C_LW{1'b1}} >> w_fill_bits);

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A full job leaves no partial line, so DRAIN takes precedence.
        if (r_committed == r_size) w_state_nxt = S_DRAIN;
        else if (flush)            w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if ((r_sym_ptr == '0) || w_flush_commit) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_issued == r_committed) && (r_rsp_cnt == r_committed)) w_state_nxt = S_DSM;
      end
      S_DSM: begin
        if (!bus.c1_almfull) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Line buffer pool (data only, no reset needed: occupancy guards reads)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[r_fill_idx][w_sym_hi -: SYM_WIDTH] <= bus.in_data;
    end else if (w_flush_commit) begin
      r_line[r_fill_idx] <= r_line[r_fill_idx] & w_pad_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, counters and write request register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_dsm       <= '0;
      r_size      <= '0;
      r_committed <= '0;
      r_issued    <= '0;
      r_rsp_cnt   <= '0;
      r_sym_ptr   <= '0;
      r_fill_idx  <= '0;
      r_drain_idx <= '0;
      r_occ       <= '0;
      r_commit_d  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
    end else if (w_start_ok) begin
      r_base      <= base_addr;
      r_dsm       <= dsm_addr;
      r_size      <= size_lines;
      r_committed <= '0;
      r_issued    <= '0;
      r_rsp_cnt   <= '0;
      r_sym_ptr   <= '0;
      r_fill_idx  <= '0;
      r_drain_idx <= '0;
      r_occ       <= '0;
      r_commit_d  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_commit_d <= w_commit;

      if (w_accept) begin
        r_sym_ptr <= w_last ? '0 : r_sym_ptr + C_PTR_W'(1);
      end else if (w_flush_commit) begin
        r_sym_ptr <= '0;
      end

      if (w_commit) begin
        r_fill_idx  <= r_fill_idx + C_IDX_W'(1);
        r_committed <= r_committed + CNT_WIDTH'(1);
      end

      if (w_issue) begin
        r_wr_valid  <= 1'b1;
        r_wr_addr   <= r_base + ADDR_WIDTH'(r_issued);
        r_wr_data   <= r_line[r_drain_idx];
        r_drain_idx <= r_drain_idx + C_IDX_W'(1);
        r_issued    <= r_issued + CNT_WIDTH'(1);
      end

      unique case ({r_commit_d, w_issue})
        2'b10:   r_occ <= r_occ + C_OCC_W'(1);
        2'b01:   r_occ <= r_occ - C_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_dsm_issue) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_dsm;
        r_wr_data  <= C_LW'(1);
        r_done     <= 1'b1;
      end

      if (bus.wr_rsp_valid && (r_state != S_IDLE)) begin
        r_rsp_cnt <= r_rsp_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign done         = r_done;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef RS_WR_COMBINER_STATS_EN
  logic [CNT_WIDTH-1:0] r_stat_bp;
  logic [CNT_WIDTH-1:0] r_stat_af;
  logic                 w_bp_evt;
  logic                 w_af_evt;

  assign w_bp_evt = (r_state == S_RUN) && bus.in_valid && !w_in_ready;
  assign w_af_evt = bus.c1_almfull &&
                    (((r_occ != '0) && w_issue_state) || (r_state == S_DSM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_bp <= '0;
      r_stat_af <= '0;
    end else if (w_start_ok) begin
      r_stat_bp <= '0;
      r_stat_af <= '0;
    end else begin
      if (w_bp_evt && (r_stat_bp != '1)) r_stat_bp <= r_stat_bp + CNT_WIDTH'(1);
      if (w_af_evt && (r_stat_af != '1)) r_stat_af <= r_stat_af + CNT_WIDTH'(1);
    end
  end

  assign stat_bp_cycles = r_stat_bp;
  assign stat_af_cycles = r_stat_af;
`else
  assign stat_bp_cycles = '0;
  assign stat_af_cycles = '0;
`endif

endmodule
`default_nettype wire
